// File: rtl/dr_mem_arb.sv
// dr_mem_arb -- merges the directory's miss-request, prefetch and writeback
// channels onto a single registered memory command channel.
//
// Each input owns a one-entry slot; an input's retry is simply "slot full".
// Arbitration looks only at registered slot state and loads the registered
// output stage, so there is no combinational path from any *_valid to mem_*.
// Accept in cycle N gives mem_valid in cycle N+2.
//
// Priority is wb > req > pfreq. Writebacks are limited to WB_BURST_MAX
// consecutive grants while a req or pfreq waits. A pfreq that waits
// PF_TIMEOUT cycles without a grant is dropped and counted in pf_drop_cnt.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   drtomem_req_*                  miss request (valid/retry, drid, cmd, paddr)
//   drtomem_pfreq_*                prefetch request (valid/retry, paddr)
//   drtomem_wb_*                   writeback (valid/retry, line, paddr)
//   mem_valid / mem_retry          merged output handshake
//   mem_kind                       00 req, 01 pfreq, 10 wb
//   mem_drid/cmd/paddr/line        merged payload (unused fields driven 0)
//   pf_drop_cnt                    saturating count of timed-out prefetches
// Width parameters REQID_W, CMD_W, PADDR_W, LINE_W give the widths of the
// reqid, command, physical-address and cache-line types.
module dr_mem_arb #(
  parameter int WB_BURST_MAX = 4,
  parameter int PF_TIMEOUT   = 32,
  parameter int REQID_W      = 6,
  parameter int CMD_W        = 4,
  parameter int PADDR_W      = 32,
  parameter int LINE_W       = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               drtomem_req_valid,
  output logic               drtomem_req_retry,
  input  logic [REQID_W-1:0] drtomem_req_drid,
  input  logic [CMD_W-1:0]   drtomem_req_cmd,
  input  logic [PADDR_W-1:0] drtomem_req_paddr,
  input  logic               drtomem_pfreq_valid,
  output logic               drtomem_pfreq_retry,
  input  logic [PADDR_W-1:0] drtomem_pfreq_paddr,
  input  logic               drtomem_wb_valid,
  output logic               drtomem_wb_retry,
  input  logic [LINE_W-1:0]  drtomem_wb_line,
  input  logic [PADDR_W-1:0] drtomem_wb_paddr,
  output logic               mem_valid,
  input  logic               mem_retry,
  output logic [1:0]         mem_kind,
  output logic [REQID_W-1:0] mem_drid,
  output logic [CMD_W-1:0]   mem_cmd,
  output logic [PADDR_W-1:0] mem_paddr,
  output logic [LINE_W-1:0]  mem_line,
  output logic [7:0]         pf_drop_cnt
);

  localparam int STREAK_W = ($clog2(WB_BURST_MAX + 1) > 3) ? $clog2(WB_BURST_MAX + 1) : 3;
  localparam int AGE_W    = ($clog2(PF_TIMEOUT) > 1) ? $clog2(PF_TIMEOUT) : 1;

  localparam logic [1:0] KIND_REQ = 2'b00;
  localparam logic [1:0] KIND_PF  = 2'b01;
  localparam logic [1:0] KIND_WB  = 2'b10;

  // Slot state
  logic               req_full_reg;
  logic [REQID_W-1:0] req_drid_reg;
  logic [CMD_W-1:0]   req_cmd_reg;
  logic [PADDR_W-1:0] req_paddr_reg;
  logic               pf_full_reg;
  logic [PADDR_W-1:0] pf_paddr_reg;
  logic               wb_full_reg;
  logic [LINE_W-1:0]  wb_line_reg;
  logic [PADDR_W-1:0] wb_paddr_reg;

  logic [STREAK_W-1:0] wb_streak_reg;
  logic [AGE_W-1:0]    pf_age_reg;

  logic req_acc, pf_acc, wb_acc;
  logic other_waiting, out_free, wb_masked;
  logic grant_wb, grant_req, grant_pf, pf_timeout;

  // Retry is "slot full" only; a slot being granted this cycle still reports
  // full, so nothing can be accepted into a slot that is emptying.
  assign drtomem_req_retry   = req_full_reg & ~reset;
  assign drtomem_pfreq_retry = pf_full_reg  & ~reset;
  assign drtomem_wb_retry    = wb_full_reg  & ~reset;

  assign req_acc = drtomem_req_valid   & ~req_full_reg & ~reset;
  assign pf_acc  = drtomem_pfreq_valid & ~pf_full_reg  & ~reset;
  assign wb_acc  = drtomem_wb_valid    & ~wb_full_reg  & ~reset;

  always_comb begin
    other_waiting = req_full_reg | pf_full_reg;
    out_free      = ~mem_valid | ~mem_retry;
    // The burst cap only bites while something else is actually waiting.
    wb_masked     = other_waiting && (wb_streak_reg == STREAK_W'(WB_BURST_MAX));
    grant_wb      = out_free & wb_full_reg & ~wb_masked;
    grant_req     = out_free & req_full_reg & ~grant_wb;
    grant_pf      = out_free & pf_full_reg & ~grant_wb & ~req_full_reg;
    // A grant in the timeout cycle takes precedence over the drop.
    pf_timeout    = pf_full_reg & ~grant_pf & (pf_age_reg == AGE_W'(PF_TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_full_reg  <= 1'b0;
      req_drid_reg  <= '0;
      req_cmd_reg   <= '0;
      req_paddr_reg <= '0;
      pf_full_reg   <= 1'b0;
      pf_paddr_reg  <= '0;
      wb_full_reg   <= 1'b0;
      wb_line_reg   <= '0;
      wb_paddr_reg  <= '0;
      wb_streak_reg <= '0;
      pf_age_reg    <= '0;
      pf_drop_cnt   <= '0;
      mem_valid     <= 1'b0;
      mem_kind      <= '0;
      mem_drid      <= '0;
      mem_cmd       <= '0;
      mem_paddr     <= '0;
      mem_line      <= '0;
    end else begin
      // Request slot: load and grant are mutually exclusive (full vs empty).
      if (req_acc) begin
        req_full_reg  <= 1'b1;
        req_drid_reg  <= drtomem_req_drid;
        req_cmd_reg   <= drtomem_req_cmd;
        req_paddr_reg <= drtomem_req_paddr;
      end else if (grant_req) begin
        req_full_reg  <= 1'b0;
      end

      // Prefetch slot with wait-age tracking.
      if (pf_acc) begin
        pf_full_reg  <= 1'b1;
        pf_paddr_reg <= drtomem_pfreq_paddr;
        pf_age_reg   <= '0;
      end else if (grant_pf || pf_timeout) begin
        pf_full_reg  <= 1'b0;
        pf_age_reg   <= '0;
      end else if (pf_full_reg) begin
        pf_age_reg   <= pf_age_reg + AGE_W'(1);
      end

      if (pf_timeout && pf_drop_cnt != 8'hFF)
        pf_drop_cnt <= pf_drop_cnt + 8'd1;

      // Writeback slot.
      if (wb_acc) begin
        wb_full_reg  <= 1'b1;
        wb_line_reg  <= drtomem_wb_line;
        wb_paddr_reg <= drtomem_wb_paddr;
      end else if (grant_wb) begin
        wb_full_reg  <= 1'b0;
      end

      // Writeback burst tracking.
      if (grant_wb && other_waiting)
        wb_streak_reg <= wb_streak_reg + STREAK_W'(1);
      else if (grant_req || grant_pf || !other_waiting)
        wb_streak_reg <= '0;

      // Output stage only changes when free, which keeps it stable under retry.
      if (out_free) begin
        mem_valid <= grant_wb | grant_req | grant_pf;
        if (grant_wb) begin
          mem_kind  <= KIND_WB;
          mem_drid  <= '0;
          mem_cmd   <= '0;
          mem_paddr <= wb_paddr_reg;
          mem_line  <= wb_line_reg;
        end else if (grant_req) begin
          mem_kind  <= KIND_REQ;
          mem_drid  <= req_drid_reg;
          mem_cmd   <= req_cmd_reg;
          mem_paddr <= req_paddr_reg;
          mem_line  <= '0;
        end else if (grant_pf) begin
          mem_kind  <= KIND_PF;
          mem_drid  <= '0;
          mem_cmd   <= '0;
          mem_paddr <= pf_paddr_reg;
          mem_line  <= '0;
        end
      end
    end
  end

endmodule
